id_ex_register: RTL and testbench



---
 rtl/id_ex_register_if.sv | 105 ++++++++++
 rtl/id_ex_register.sv | 138 +++++++++++++
 tb/tb_id_ex_register.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_register_if.sv
// ID/EX register port bundle: ID-side operands/controls in,
// EX-side registered copies, interlock request and bubble counter out.
interface id_ex_register_if #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
);
    logic            flush;
    logic            stall;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus_4;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_read_data1;
    logic [XLEN-1:0] id_read_data2;
    logic [XLEN-1:0] id_csr_read_data;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [6:0]      id_opcode;
    logic            id_jump;
    logic            id_branch;
    logic            id_csr_write_enable;
    logic            id_register_file_write;
    logic            id_memory_read;
    logic            id_memory_write;
    logic [1:0]      id_alu_src_A_select;
    logic [2:0]      id_alu_src_B_select;
    logic [2:0]      id_register_file_write_data_select;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_pc_plus_4;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_read_data1;
    logic [XLEN-1:0] ex_read_data2;
    logic [XLEN-1:0] ex_csr_read_data;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [6:0]      ex_opcode;
    logic            ex_jump;
    logic            ex_branch;
    logic            ex_csr_write_enable;
    logic            ex_register_file_write;
    logic            ex_memory_read;
    logic            ex_memory_write;
    logic [1:0]      ex_alu_src_A_select;
    logic [2:0]      ex_alu_src_B_select;
    logic [2:0]      ex_register_file_write_data_select;

    logic                 load_use_stall;
    logic [CNT_WIDTH-1:0] bubble_count;

    modport master (
        output flush, stall, id_valid,
        output id_pc, id_pc_plus_4, id_imm,
        output id_read_data1, id_read_data2, id_csr_read_data,
        output id_rs1, id_rs2, id_rd,
        output id_funct3, id_funct7, id_opcode,
        output id_jump, id_branch, id_csr_write_enable,
        output id_register_file_write,
        output id_memory_read, id_memory_write,
        output id_alu_src_A_select, id_alu_src_B_select,
        output id_register_file_write_data_select,
        input  ex_valid,
        input  ex_pc, ex_pc_plus_4, ex_imm,
        input  ex_read_data1, ex_read_data2, ex_csr_read_data,
        input  ex_rs1, ex_rs2, ex_rd,
        input  ex_funct3, ex_funct7, ex_opcode,
        input  ex_jump, ex_branch, ex_csr_write_enable,
        input  ex_register_file_write,
        input  ex_memory_read, ex_memory_write,
        input  ex_alu_src_A_select, ex_alu_src_B_select,
        input  ex_register_file_write_data_select,
        input  load_use_stall, bubble_count
    );

    modport slave (
        input  flush, stall, id_valid,
        input  id_pc, id_pc_plus_4, id_imm,
        input  id_read_data1, id_read_data2, id_csr_read_data,
        input  id_rs1, id_rs2, id_rd,
        input  id_funct3, id_funct7, id_opcode,
        input  id_jump, id_branch, id_csr_write_enable,
        input  id_register_file_write,
        input  id_memory_read, id_memory_write,
        input  id_alu_src_A_select, id_alu_src_B_select,
        input  id_register_file_write_data_select,
        output ex_valid,
        output ex_pc, ex_pc_plus_4, ex_imm,
        output ex_read_data1, ex_read_data2, ex_csr_read_data,
        output ex_rs1, ex_rs2, ex_rd,
        output ex_funct3, ex_funct7, ex_opcode,
        output ex_jump, ex_branch, ex_csr_write_enable,
        output ex_register_file_write,
        output ex_memory_read, ex_memory_write,
        output ex_alu_src_A_select, ex_alu_src_B_select,
        output ex_register_file_write_data_select,
        output load_use_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: flush/stall/load-use bubble insertion,
// load-use interlock request and saturating bubble counter.
module id_ex_register #(
    parameter int         XLEN           = 32,
    parameter int         CNT_WIDTH      = 32,
    parameter logic [1:0] ALU_SRC_A_NONE = 2'b11,
    parameter logic [2:0] ALU_SRC_B_NONE = 3'b111,
    parameter logic [2:0] RF_WD_NONE     = 3'b111
) (
    input logic             clk,
    input logic             reset,
    id_ex_register_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] read_data1;
        logic [XLEN-1:0] read_data2;
        logic [XLEN-1:0] csr_read_data;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [6:0]      opcode;
        logic            jump;
        logic            branch;
        logic            csr_we;
        logic            rf_we;
        logic            mem_rd;
        logic            mem_wr;
        logic [1:0]      a_sel;
        logic [2:0]      b_sel;
        logic [2:0]      wd_sel;
    } word_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    word_t                q;
    word_t                bubble_w;
    word_t                id_w;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 hazard;
    logic                 load_bubble;
    logic                 load_id;

    // Bubble word: invalid, no side effects, selects parked on NONE.
    always_comb begin
        bubble_w        = '0;
        bubble_w.a_sel  = ALU_SRC_A_NONE;
        bubble_w.b_sel  = ALU_SRC_B_NONE;
        bubble_w.wd_sel = RF_WD_NONE;
    end

    // ID word copied verbatim; state-changing controls gated by id_valid.
    always_comb begin
        id_w               = '0;
        id_w.valid         = bus.id_valid;
        id_w.pc            = bus.id_pc;
        id_w.pc_plus_4     = bus.id_pc_plus_4;
        id_w.imm           = bus.id_imm;
        id_w.read_data1    = bus.id_read_data1;
        id_w.read_data2    = bus.id_read_data2;
        id_w.csr_read_data = bus.id_csr_read_data;
        id_w.rs1           = bus.id_rs1;
        id_w.rs2           = bus.id_rs2;
        id_w.rd            = bus.id_rd;
        id_w.funct3        = bus.id_funct3;
        id_w.funct7        = bus.id_funct7;
        id_w.opcode        = bus.id_opcode;
        id_w.jump          = bus.id_jump;
        id_w.branch        = bus.id_branch;
        id_w.csr_we        = bus.id_csr_write_enable & bus.id_valid;
        id_w.rf_we         = bus.id_register_file_write & bus.id_valid;
        id_w.mem_rd        = bus.id_memory_read;
        id_w.mem_wr        = bus.id_memory_write & bus.id_valid;
        id_w.a_sel         = bus.id_alu_src_A_select;
        id_w.b_sel         = bus.id_alu_src_B_select;
        id_w.wd_sel        = bus.id_register_file_write_data_select;
    end

    // Conservative load-use check against both source fields.
    always_comb begin
        hazard = q.valid & q.mem_rd & (q.rd != 5'd0) & bus.id_valid
               & ((bus.id_rs1 == q.rd) | (bus.id_rs2 == q.rd));
        load_bubble = bus.flush | (~bus.stall & hazard);
        load_id     = ~bus.flush & ~bus.stall & ~hazard;
    end

    // Pipeline word: flush > stall > load-use bubble > capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= bubble_w;
        end else if (load_bubble) begin
            q <= bubble_w;
        end else if (load_id) begin
            q <= id_w;
        end
    end

    // Saturating count of inserted bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load_bubble && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign bus.load_use_stall = hazard & ~bus.flush;
    assign bus.bubble_count   = cnt;

    assign bus.ex_valid                           = q.valid;
    assign bus.ex_pc                              = q.pc;
    assign bus.ex_pc_plus_4                       = q.pc_plus_4;
    assign bus.ex_imm                             = q.imm;
    assign bus.ex_read_data1                      = q.read_data1;
    assign bus.ex_read_data2                      = q.read_data2;
    assign bus.ex_csr_read_data                   = q.csr_read_data;
    assign bus.ex_rs1                             = q.rs1;
    assign bus.ex_rs2                             = q.rs2;
    assign bus.ex_rd                              = q.rd;
    assign bus.ex_funct3                          = q.funct3;
    assign bus.ex_funct7                          = q.funct7;
    assign bus.ex_opcode                          = q.opcode;
    assign bus.ex_jump                            = q.jump;
    assign bus.ex_branch                          = q.branch;
    assign bus.ex_csr_write_enable                = q.csr_we;
    assign bus.ex_register_file_write             = q.rf_we;
    assign bus.ex_memory_read                     = q.mem_rd;
    assign bus.ex_memory_write                    = q.mem_wr;
    assign bus.ex_alu_src_A_select                = q.a_sel;
    assign bus.ex_alu_src_B_select                = q.b_sel;
    assign bus.ex_register_file_write_data_select = q.wd_sel;
endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: reference model, per-cycle compare,
// directed hazard/priority/reset/saturation vectors.
module tb_id_ex_register;
    localparam logic [1:0] A_NONE = 2'b11;
    localparam logic [2:0] B_NONE = 3'b111;
    localparam logic [2:0] WD_NONE = 3'b111;
    localparam logic [2:0] WD_ALU = 3'b000;
    localparam logic [2:0] WD_MEM = 3'b010;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, pc4, imm, rd1, rd2, csr;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic        jump, branch, csr_we, rf_we, mem_rd, mem_wr;
        logic [1:0]  a_sel;
        logic [2:0]  b_sel, wd_sel;
    } mw_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    mw_t  m;
    logic [31:0] mcnt;

    id_ex_register_if #(.XLEN(32), .CNT_WIDTH(32)) bus ();
    id_ex_register_if #(.XLEN(32), .CNT_WIDTH(4))  bus2 ();

    id_ex_register #(.XLEN(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    id_ex_register #(.XLEN(32), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mw_t bubble();
        mw_t w = '0;
        w.a_sel = A_NONE;
        w.b_sel = B_NONE;
        w.wd_sel = WD_NONE;
        return w;
    endfunction

    function automatic mw_t capture();
        mw_t w;
        w.valid = bus.id_valid;
        w.pc = bus.id_pc;
        w.pc4 = bus.id_pc_plus_4;
        w.imm = bus.id_imm;
        w.rd1 = bus.id_read_data1;
        w.rd2 = bus.id_read_data2;
        w.csr = bus.id_csr_read_data;
        w.rs1 = bus.id_rs1;
        w.rs2 = bus.id_rs2;
        w.rd = bus.id_rd;
        w.f3 = bus.id_funct3;
        w.f7 = bus.id_funct7;
        w.op = bus.id_opcode;
        w.jump = bus.id_jump;
        w.branch = bus.id_branch;
        w.csr_we = bus.id_valid ? bus.id_csr_write_enable : 1'b0;
        w.rf_we = bus.id_valid ? bus.id_register_file_write : 1'b0;
        w.mem_rd = bus.id_memory_read;
        w.mem_wr = bus.id_valid ? bus.id_memory_write : 1'b0;
        w.a_sel = bus.id_alu_src_A_select;
        w.b_sel = bus.id_alu_src_B_select;
        w.wd_sel = bus.id_register_file_write_data_select;
        return w;
    endfunction

    // A load sits in EX and the ID instruction names its destination.
    function automatic bit model_hazard();
        if (!(m.valid && m.mem_rd && m.rd != 0 && bus.id_valid)) return 1'b0;
        return (bus.id_rs1 == m.rd) || (bus.id_rs2 == m.rd);
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 1;
    endfunction

    // Reference model of the EX-side state.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m = bubble();
            mcnt = 0;
        end else if (bus.flush) begin
            m = bubble();
            mcnt = sat_inc(mcnt);
        end else if (bus.stall) begin
            m = m;
        end else if (model_hazard()) begin
            m = bubble();
            mcnt = sat_inc(mcnt);
        end else begin
            m = capture();
        end
    end

    // Compare DUT against model every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ex_word", 256'({bus.ex_valid, bus.ex_pc, bus.ex_pc_plus_4,
                bus.ex_imm, bus.ex_read_data1, bus.ex_read_data2,
                bus.ex_csr_read_data, bus.ex_rs1, bus.ex_rs2, bus.ex_rd,
                bus.ex_funct3, bus.ex_funct7, bus.ex_opcode, bus.ex_jump,
                bus.ex_branch, bus.ex_csr_write_enable,
                bus.ex_register_file_write, bus.ex_memory_read,
                bus.ex_memory_write, bus.ex_alu_src_A_select,
                bus.ex_alu_src_B_select,
                bus.ex_register_file_write_data_select}), 256'(m));
            check("bubble_count", 256'(bus.bubble_count), 256'(mcnt));
            check("load_use_stall", 256'(bus.load_use_stall),
                256'(model_hazard() && !bus.flush));
        end
    end

    task automatic drive(logic v, logic [31:0] pc, logic [4:0] rs1,
                         logic [4:0] rs2, logic [4:0] rd, logic [6:0] op,
                         logic rfwe, logic mrd, logic mwr, logic csrwe,
                         logic [2:0] wdsel);
        bus.id_valid = v;
        bus.id_pc = pc;
        bus.id_pc_plus_4 = pc + 4;
        bus.id_imm = $urandom;
        bus.id_read_data1 = $urandom;
        bus.id_read_data2 = $urandom;
        bus.id_csr_read_data = $urandom;
        bus.id_rs1 = rs1;
        bus.id_rs2 = rs2;
        bus.id_rd = rd;
        bus.id_funct3 = pc[4:2];
        bus.id_funct7 = pc[10:4];
        bus.id_opcode = op;
        bus.id_jump = pc[2];
        bus.id_branch = pc[3];
        bus.id_csr_write_enable = csrwe;
        bus.id_register_file_write = rfwe;
        bus.id_memory_read = mrd;
        bus.id_memory_write = mwr;
        bus.id_alu_src_A_select = pc[3:2];
        bus.id_alu_src_B_select = {1'b0, pc[3:2]};
        bus.id_register_file_write_data_select = wdsel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        drive(1'b1, $urandom, 5'd9, 5'd10, 5'd11, OP_LD, 1, 1, 1, 1, WD_MEM);
        bus2.flush = 1'b0;
        bus2.stall = 1'b0;
        bus2.id_valid = 1'b0;
        bus2.id_pc = '0;
        bus2.id_pc_plus_4 = '0;
        bus2.id_imm = '0;
        bus2.id_read_data1 = '0;
        bus2.id_read_data2 = '0;
        bus2.id_csr_read_data = '0;
        bus2.id_rs1 = '0;
        bus2.id_rs2 = '0;
        bus2.id_rd = '0;
        bus2.id_funct3 = '0;
        bus2.id_funct7 = '0;
        bus2.id_opcode = '0;
        bus2.id_jump = 1'b0;
        bus2.id_branch = 1'b0;
        bus2.id_csr_write_enable = 1'b0;
        bus2.id_register_file_write = 1'b0;
        bus2.id_memory_read = 1'b0;
        bus2.id_memory_write = 1'b0;
        bus2.id_alu_src_A_select = '0;
        bus2.id_alu_src_B_select = '0;
        bus2.id_register_file_write_data_select = '0;

        // Reset between edges
        #3 reset = 1'b0;
        #1;
        chk_on = 1'b1;
        check("rst_valid", 256'(bus.ex_valid), 256'(0));
        check("rst_asel", 256'(bus.ex_alu_src_A_select), 256'(A_NONE));
        check("rst_wdsel", 256'(bus.ex_register_file_write_data_select), 256'(WD_NONE));
        check("rst_cnt", 256'(bus.bubble_count), 256'(0));
        check("rst_lus", 256'(bus.load_use_stall), 256'(0));
        #4 reset = 1'b1;

        // ADD x3,x1,x2 pass-through
        drive(1, 32'h100, 5'd1, 5'd2, 5'd3, OP_R, 1, 0, 0, 0, WD_ALU);
        tick();
        check("pt_pc", 256'(bus.ex_pc), 256'(32'h100));
        check("pt_rd", 256'(bus.ex_rd), 256'(3));
        check("pt_rfwe", 256'(bus.ex_register_file_write), 256'(1));
        check("pt_wdsel", 256'(bus.ex_register_file_write_data_select), 256'(WD_ALU));

        // LW x5 then ADDI x6,x5 -> one bubble
        drive(1, 32'h104, 5'd2, 5'd0, 5'd5, OP_LD, 1, 1, 0, 0, WD_MEM);
        tick();
        drive(1, 32'h108, 5'd5, 5'd0, 5'd6, OP_I, 1, 0, 0, 0, WD_ALU);
        #1 check("lu_stall", 256'(bus.load_use_stall), 256'(1));
        tick();
        check("lu_bubble", 256'(bus.ex_valid), 256'(0));
        check("lu_cnt", 256'(bus.bubble_count), 256'(1));
        check("lu_clear", 256'(bus.load_use_stall), 256'(0));
        tick();
        check("lu_rs1", 256'(bus.ex_rs1), 256'(5));
        check("lu_pc", 256'(bus.ex_pc), 256'(32'h108));

        // Load to x0 never interlocks
        drive(1, 32'h10c, 5'd1, 5'd0, 5'd0, OP_LD, 1, 1, 0, 0, WD_MEM);
        tick();
        drive(1, 32'h110, 5'd0, 5'd0, 5'd7, OP_I, 1, 0, 0, 0, WD_ALU);
        #1 check("x0_nostall", 256'(bus.load_use_stall), 256'(0));
        tick();
        check("x0_pc", 256'(bus.ex_pc), 256'(32'h110));

        // Flush beats stall
        drive(1, 32'h114, 5'd1, 5'd2, 5'd8, OP_R, 1, 0, 0, 0, WD_ALU);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        tick();
        check("fs_valid", 256'(bus.ex_valid), 256'(0));
        check("fs_cnt", 256'(bus.bubble_count), 256'(2));
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200 + 4 * i, 5'd3, 5'd4, 5'd9, OP_R, 1, 0, 1, 1, WD_ALU);
            tick();
            check("st_pc", 256'(bus.ex_pc), 256'(32'h114));
            check("st_cnt", 256'(bus.bubble_count), 256'(2));
        end
        bus.stall = 1'b0;

        // Stall with hazard holds; flush with hazard masks the request
        drive(1, 32'h118, 5'd1, 5'd0, 5'd7, OP_LD, 1, 1, 0, 0, WD_MEM);
        tick();
        drive(1, 32'h11c, 5'd2, 5'd7, 5'd10, OP_R, 1, 0, 0, 0, WD_ALU);
        bus.stall = 1'b1;
        #1 check("sh_lus", 256'(bus.load_use_stall), 256'(1));
        tick();
        check("sh_pc", 256'(bus.ex_pc), 256'(32'h118));
        check("sh_cnt", 256'(bus.bubble_count), 256'(2));
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        #1 check("fh_lus", 256'(bus.load_use_stall), 256'(0));
        tick();
        check("fh_cnt", 256'(bus.bubble_count), 256'(3));
        bus.flush = 1'b0;
        tick();
        check("fh_pc", 256'(bus.ex_pc), 256'(32'h11c));

        // Invalid ID word: copied but side effects cleared
        drive(0, 32'h120, 5'd1, 5'd2, 5'd3, OP_R, 1, 0, 1, 1, WD_ALU);
        tick();
        check("inv_valid", 256'(bus.ex_valid), 256'(0));
        check("inv_mwr", 256'(bus.ex_memory_write), 256'(0));
        check("inv_rfwe", 256'(bus.ex_register_file_write), 256'(0));
        check("inv_pc", 256'(bus.ex_pc), 256'(32'h120));
        check("inv_cnt", 256'(bus.bubble_count), 256'(3));

        // Reset mid-operation acts without a clock edge
        drive(1, 32'h124, 5'd1, 5'd2, 5'd3, OP_R, 1, 0, 0, 0, WD_ALU);
        tick();
        #2 reset = 1'b0;
        #1;
        check("mr_valid", 256'(bus.ex_valid), 256'(0));
        check("mr_pc", 256'(bus.ex_pc), 256'(0));
        check("mr_cnt", 256'(bus.bubble_count), 256'(0));
        #2 reset = 1'b1;
        tick();
        check("mr_reload", 256'(bus.ex_pc), 256'(32'h124));

        // Saturating 4-bit counter
        bus2.flush = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 13) check("sat_14", 256'(bus2.bubble_count), 256'(14));
        end
        check("sat_17", 256'(bus2.bubble_count), 256'(15));
        bus2.flush = 1'b0;

        tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
